// File: rtl/phys_pkg.sv
// Shared types and helpers for the physical register free list.
// Storage depth, reserved range and index width live here.
package phys_pkg;

  localparam int CELLS = 128;
  localparam int RESERVED = 32;
  localparam int PHYS_ADDR_WIDTH = $clog2(CELLS);

  typedef logic [PHYS_ADDR_WIDTH-1:0] phys_addr_t;

  typedef enum logic {
    INIT,
    RUN
  } fl_state_t;

  function automatic logic [5:0] popcount(
    input logic [31:0] v
  );
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + 6'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/phys_free_list_if.sv
// Rename/retire side bundle of the free list:
// allocation requests/grants and release writes.
interface phys_free_list_if #(
  parameter int ALLOC_PORTS = 4,
  parameter int FREE_PORTS = 4
);
  import phys_pkg::*;

  logic [ALLOC_PORTS-1:0] alloc_req;
  logic [ALLOC_PORTS-1:0] alloc_gnt;
  phys_addr_t [ALLOC_PORTS-1:0] alloc_addr;
  logic [FREE_PORTS-1:0] free_en;
  phys_addr_t [FREE_PORTS-1:0] free_addr;

  modport master (
    output alloc_req,
    output free_en,
    output free_addr,
    input  alloc_gnt,
    input  alloc_addr
  );

  modport slave (
    input  alloc_req,
    input  free_en,
    input  free_addr,
    output alloc_gnt,
    output alloc_addr
  );

endinterface

// File: rtl/free_port_compact.sv
// Turns a per-port valid vector into exclusive prefix
// offsets (slot of each set port) plus the set count.
module free_port_compact
  import phys_pkg::*;
#(
  parameter int N = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]         vec,
  output logic [N-1:0][CW-1:0] off,
  output logic [CW-1:0]        total
);

  // ripple prefix sum across ports in ascending order
  always_comb begin
    logic [CW-1:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      off[i] = acc;
      acc = acc + CW'(vec[i]);
    end
    total = CW'(popcount(32'(vec)));
  end

endmodule

// File: rtl/phys_free_list.sv
// Circular free list of physical register indices.
// Define PHYS_FREE_LIST_CKPT_EN for head checkpoint/restore.
module phys_free_list
  import phys_pkg::*;
#(
  parameter int ALLOC_PORTS = 4,
  parameter int FREE_PORTS = 4,
  parameter int CNT_WIDTH = $clog2(CELLS + 1)
) (
  input  logic                 clk,
  input  logic                 async_rst_n,
  input  logic                 clk_en,
`ifdef PHYS_FREE_LIST_CKPT_EN
  input  logic                 ckpt_save,
  input  logic                 ckpt_restore,
`endif
  output logic                 ready,
  phys_free_list_if.slave      fl,
  output logic [CNT_WIDTH-1:0] free_count,
  output logic                 overflow_err
);

  localparam int AW = PHYS_ADDR_WIDTH;
  localparam int ACW = $clog2(ALLOC_PORTS + 1);
  localparam int FCW = $clog2(FREE_PORTS + 1);
  localparam int LIMIT = CELLS - RESERVED;

  phys_addr_t mem [CELLS];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] k;

  fl_state_t state;
  fl_state_t state_nxt;
  logic init_wr;

  logic [ALLOC_PORTS-1:0][ACW-1:0] a_off;
  logic [ACW-1:0] a_tot;
  logic [FREE_PORTS-1:0][FCW-1:0] f_off;
  logic [FCW-1:0] f_tot;

  logic run_en;
  logic restore;
  logic alloc_ok;
  logic [ACW-1:0] n_gnt;
  logic [CNT_WIDTH-1:0] cnt_base;
  logic [CNT_WIDTH:0] cnt_wide;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic rel_ovf;
  logic rel_ok;

`ifdef PHYS_FREE_LIST_CKPT_EN
  logic [AW-1:0] ckpt_head;
  assign restore = run_en && ckpt_restore;
`else
  assign restore = 1'b0;
`endif

  free_port_compact #(.N(ALLOC_PORTS)) u_alloc_cmp (
    .vec   (fl.alloc_req),
    .off   (a_off),
    .total (a_tot)
  );

  free_port_compact #(.N(FREE_PORTS)) u_free_cmp (
    .vec   (fl.free_en),
    .off   (f_off),
    .total (f_tot)
  );

  // FSM state register
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: INIT ends after the last fill write
  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT: begin
        if (clk_en && k == CNT_WIDTH'(LIMIT - 1)) begin
          state_nxt = RUN;
        end
      end
      RUN: state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready = (state == RUN);
    init_wr = (state == INIT) && clk_en;
  end

  // all-or-nothing grants, addresses looked up from head
  always_comb begin
    run_en = ready && clk_en;
    alloc_ok = run_en && !restore &&
               (count >= CNT_WIDTH'(a_tot));
    fl.alloc_gnt = alloc_ok ? fl.alloc_req : '0;
    n_gnt = alloc_ok ? a_tot : '0;
    for (int i = 0; i < ALLOC_PORTS; i++) begin
      fl.alloc_addr[i] = mem[head + AW'(a_off[i])];
    end
  end

  // next count and release overflow detection
  always_comb begin
`ifdef PHYS_FREE_LIST_CKPT_EN
    if (restore) begin
      cnt_base = count + CNT_WIDTH'(head - ckpt_head);
    end else begin
      cnt_base = count - CNT_WIDTH'(n_gnt);
    end
`else
    cnt_base = count - CNT_WIDTH'(n_gnt);
`endif
    cnt_wide = {1'b0, cnt_base} + (CNT_WIDTH + 1)'(f_tot);
    rel_ovf = run_en &&
              (cnt_wide > (CNT_WIDTH + 1)'(LIMIT));
    rel_ok = run_en && !rel_ovf;
    cnt_nxt = rel_ok ? cnt_base + CNT_WIDTH'(f_tot)
                     : cnt_base;
  end

  // pointers, count and sticky overflow flag
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      k <= '0;
      overflow_err <= 1'b0;
    end else if (init_wr) begin
      tail <= tail + 1'b1;
      count <= count + 1'b1;
      k <= k + 1'b1;
    end else if (run_en) begin
      if (restore) begin
`ifdef PHYS_FREE_LIST_CKPT_EN
        head <= ckpt_head;
`endif
      end else begin
        head <= head + AW'(n_gnt);
      end
      count <= cnt_nxt;
      if (rel_ok) begin
        tail <= tail + AW'(f_tot);
      end
      if (rel_ovf) begin
        overflow_err <= 1'b1;
      end
    end
  end

  // storage writes: fill pattern, then compacted releases
  always_ff @(posedge clk) begin
    if (init_wr) begin
      mem[tail] <= phys_addr_t'(k) + phys_addr_t'(RESERVED);
    end else if (rel_ok) begin
      for (int i = 0; i < FREE_PORTS; i++) begin
        if (fl.free_en[i]) begin
          mem[tail + AW'(f_off[i])] <= fl.free_addr[i];
        end
      end
    end
  end

`ifdef PHYS_FREE_LIST_CKPT_EN
  // checkpoint head after this cycle's grants
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      ckpt_head <= '0;
    end else if (run_en && ckpt_save && !restore) begin
      ckpt_head <= head + AW'(n_gnt);
    end
  end
`endif

  assign free_count = count;

endmodule

// File: tb/tb_phys_free_list.sv
// Directed bench for phys_free_list: init fill, grants,
// starvation, release visibility, wrap, overflow, ckpt.
module tb_phys_free_list;
  import phys_pkg::*;

  logic clk = 1'b0;
  logic async_rst_n = 1'b0;
  logic clk_en = 1'b0;
  logic ready;
  logic overflow_err;
  logic [7:0] free_count;
`ifdef PHYS_FREE_LIST_CKPT_EN
  logic ckpt_save = 1'b0;
  logic ckpt_restore = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  phys_free_list_if #(
    .ALLOC_PORTS(4),
    .FREE_PORTS(4)
  ) fl ();

  phys_free_list dut (
    .clk          (clk),
    .async_rst_n  (async_rst_n),
    .clk_en       (clk_en),
`ifdef PHYS_FREE_LIST_CKPT_EN
    .ckpt_save    (ckpt_save),
    .ckpt_restore (ckpt_restore),
`endif
    .ready        (ready),
    .fl           (fl),
    .free_count   (free_count),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fl.alloc_req = '0;
    fl.free_en = '0;
    fl.free_addr = '0;
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (!ready && n < 300) begin
      step();
      n++;
    end
    check("init_cycles", n, 96);
    check("init_count", free_count, 96);
    check("init_ovf", overflow_err, 0);
  endtask

  task automatic do_reset();
    idle_inputs();
    #1 async_rst_n = 1'b0;
    step();
    async_rst_n = 1'b1;
    clk_en = 1'b1;
  endtask

  initial begin
    idle_inputs();
    fl.alloc_req = 4'b1111;
    #2;
    check("rst_ready", ready, 0);
    check("rst_count", free_count, 0);
    check("rst_gnt", fl.alloc_gnt, 0);
    check("rst_ovf", overflow_err, 0);
    step();
    async_rst_n = 1'b1;
    clk_en = 1'b0;
    repeat (3) step();
    check("clken_hold", free_count, 0);
    clk_en = 1'b1;
    fl.free_en = 4'b0001;
    fl.free_addr[0] = 7'd3;
    #1;
    check("init_gnt", fl.alloc_gnt, 0);
    wait_init();
    idle_inputs();

    // overflow at full list, allocation unaffected
    fl.free_en = 4'b0001;
    fl.free_addr[0] = 7'd7;
    step();
    fl.free_en = '0;
    check("ovf_set", overflow_err, 1);
    check("ovf_count", free_count, 96);
    fl.alloc_req = 4'b1111;
    #1;
    check("a4_gnt", fl.alloc_gnt, 4'b1111);
    check("a4_p0", fl.alloc_addr[0], 32);
    check("a4_p1", fl.alloc_addr[1], 33);
    check("a4_p2", fl.alloc_addr[2], 34);
    check("a4_p3", fl.alloc_addr[3], 35);
    step();
    fl.alloc_req = '0;
    check("a4_count", free_count, 92);
    check("ovf_sticky", overflow_err, 1);
    #2 async_rst_n = 1'b0;
    #1;
    check("ovf_async_clr", overflow_err, 0);
    check("async_count", free_count, 0);
    check("async_ready", ready, 0);

    // sparse request right after init
    do_reset();
    wait_init();
    fl.alloc_req = 4'b1010;
    #1;
    check("sp_gnt", fl.alloc_gnt, 4'b1010);
    check("sp_p1", fl.alloc_addr[1], 32);
    check("sp_p3", fl.alloc_addr[3], 33);
    step();
    check("sp_count", free_count, 94);
    fl.alloc_req = 4'b0001;
    #1;
    check("sp_head", fl.alloc_addr[0], 34);
    step();

    // drain to two, then starve a 3-wide request
    fl.alloc_req = 4'b1111;
    repeat (22) step();
    fl.alloc_req = 4'b0111;
    step();
    check("drain_count", free_count, 2);
    fl.alloc_req = 4'b0111;
    #1;
    check("starve_gnt", fl.alloc_gnt, 0);
    step();
    check("starve_count", free_count, 2);
    fl.alloc_req = 4'b0011;
    #1;
    check("last_gnt", fl.alloc_gnt, 4'b0011);
    check("last_p0", fl.alloc_addr[0], 126);
    check("last_p1", fl.alloc_addr[1], 127);
    step();
    check("empty_count", free_count, 0);

    // same-cycle release is not allocatable
    fl.alloc_req = 4'b0001;
    fl.free_en = 4'b0011;
    fl.free_addr[0] = 7'd5;
    fl.free_addr[1] = 7'd9;
    #1;
    check("rel_nogrant", fl.alloc_gnt, 0);
    step();
    fl.free_en = '0;
    check("rel_count", free_count, 2);
    #1;
    check("rel_gnt", fl.alloc_gnt, 4'b0001);
    check("rel_a5", fl.alloc_addr[0], 5);
    step();
    check("rel_a9", fl.alloc_addr[0], 9);
    step();
    fl.alloc_req = '0;
    check("rel_empty", free_count, 0);

    // wrap both pointers past CELLS
    for (int b = 0; b < 8; b++) begin
      fl.free_en = 4'b1111;
      for (int i = 0; i < 4; i++) begin
        fl.free_addr[i] = 7'(40 + 4 * b + i);
      end
      step();
    end
    fl.free_en = '0;
    check("wrap_fill", free_count, 32);
    for (int b = 0; b < 8; b++) begin
      fl.alloc_req = 4'b1111;
      #1;
      for (int i = 0; i < 4; i++) begin
        check("wrap_addr", fl.alloc_addr[i], 40 + 4 * b + i);
      end
      step();
    end
    fl.alloc_req = '0;
    check("wrap_empty", free_count, 0);

`ifdef PHYS_FREE_LIST_CKPT_EN
    do_reset();
    wait_init();
    fl.alloc_req = 4'b1111;
    repeat (10) step();
    fl.alloc_req = '0;
    check("ck_count40", free_count, 56);
    ckpt_save = 1'b1;
    step();
    ckpt_save = 1'b0;
    fl.alloc_req = 4'b1111;
    repeat (2) step();
    check("ck_count48", free_count, 48);
    ckpt_restore = 1'b1;
    fl.free_en = 4'b0001;
    fl.free_addr[0] = 7'd3;
    #1;
    check("ck_rst_gnt", fl.alloc_gnt, 0);
    step();
    ckpt_restore = 1'b0;
    fl.free_en = '0;
    fl.alloc_req = 4'b0001;
    check("ck_count", free_count, 57);
    #1;
    check("ck_head", fl.alloc_addr[0], 72);
    step();
    fl.alloc_req = '0;
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
